data_memory_ctrl: RTL and testbench

//   Parametrised data memory for the MIPS datapath: DEPTH=2**ADDR_W words of DATA_W bits.

---
 rtl/data_memory_ctrl_pkg.sv | 17 +
 rtl/data_memory_ctrl_if.sv | 23 ++
 rtl/data_memory_ctrl_dmem_array.sv | 26 ++
 rtl/data_memory_ctrl.sv | 124 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and defaults for the MIPS data memory controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package data_memory_ctrl_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;

  // ST_CLEAR is only reachable when the power-on clear sweep is built in.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
// Latency: n/a (wires only).
// Backpressure: master holds req until it sees ready=1 at a clock edge.
// Signals: req/we/addr/wdata from master; ready/ack/rdata from slave.
interface data_memory_ctrl_if
  import data_memory_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, ack, rdata);
  modport slave  (input req, we, addr, wdata, output ready, ack, rdata);

endinterface

// File: rtl/data_memory_ctrl_dmem_array.sv
// Storage array: 2**ADDR_W words of DATA_W bits.
// Latency: write lands on the clock edge, read port is combinational.
// Backpressure: none; always accepts a write.
// Ports: clk, i_we/i_waddr/i_wdata (write port), i_raddr/o_rdata (read port).
module data_memory_ctrl_dmem_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Contents deliberately have no reset: only the optional clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_memory_ctrl.sv
// MIPS data memory with req/ready/ack handshake, WAIT_CYCLES wait states, registered rdata.
// Latency: ack is high in the (WAIT_CYCLES+1)th cycle after the accepting edge.
// Backpressure: ready=0 outside IDLE; req is ignored (not queued) until ready returns.
// Ports: clk, rst_n (async active-low), bus (slave modport of data_memory_ctrl_if).
// Build option DMEM_CLEAR_EN: after reset, sweep zeros into every word before going IDLE.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  data_memory_ctrl_if.slave bus
);

  localparam int          DEPTH     = 2**ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef DMEM_CLEAR_EN
  localparam state_t      RST_STATE = ST_CLEAR;
`else
  localparam state_t      RST_STATE = ST_IDLE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_is_read;
  logic              w_rd_load;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_mem_rdata;

`ifdef DMEM_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr;
`endif

  assign w_accept = (r_state == ST_IDLE) && bus.req;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  // Next state, handshake outputs and array controls
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = w_accept && bus.we;
    w_mem_waddr = bus.addr;
    w_mem_wdata = bus.wdata;
    // In IDLE the access being accepted has not been latched yet, so look at the bus.
    w_rd_addr   = (r_state == ST_IDLE) ? bus.addr : r_addr;
    w_is_read   = (r_state == ST_IDLE) ? !bus.we  : !r_we;
    case (r_state)
`ifdef DMEM_CLEAR_EN
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_clr_addr;
        w_mem_wdata = '0;
        if (r_clr_addr == ADDR_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      end
`endif
      ST_IDLE: if (bus.req) w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // rdata is captured on the edge that enters RESP, reads only.
    w_rd_load = (w_state_nxt == ST_RESP) && (r_state != ST_RESP) && w_is_read;
  end

  // Request latches, wait counter, read data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we   <= bus.we;
        r_addr <= bus.addr;
        r_cnt  <= WAIT_INIT;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd_load) r_rdata <= w_mem_rdata;
    end
  end

`ifdef DMEM_CLEAR_EN
  // Reset during the sweep restarts it from word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_clr_addr <= '0;
    else if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
  end
`endif

  assign bus.ready = (r_state == ST_IDLE);
  assign bus.ack   = (r_state == ST_RESP);
  assign bus.rdata = r_rdata;

  data_memory_ctrl_dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: four configurations side by side, directed table,
// hand-written corner sequences and randomized traffic against a behavioural model.
module tb_data_memory_ctrl;

  localparam int PERIOD = 10;
  // Per-instance configuration: instances 0..2 are 4x16, instance 3 is 8x64.
  localparam int WAITV [4] = '{1, 0, 3, 1};
  localparam int AMASK [4] = '{15, 15, 15, 63};
  localparam int DMASK [4] = '{15, 15, 15, 255};
  localparam int DEPTHV[4] = '{16, 16, 16, 64};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] t_req;
  logic       t_we;
  logic [5:0] t_addr;
  logic [7:0] t_wdata;

  logic [3:0] m_ready;
  logic [3:0] m_ack;
  logic [7:0] m_rdata [4];

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: word contents, which words hold a known value, last read value.
  logic [7:0] mdl_mem [4][64];
  bit         mdl_vld [4][64];
  logic [7:0] mdl_rd  [4];

  always #(PERIOD/2) clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(4), .ADDR_W(4)) if0 ();
  data_memory_ctrl_if #(.DATA_W(4), .ADDR_W(4)) if1 ();
  data_memory_ctrl_if #(.DATA_W(4), .ADDR_W(4)) if2 ();
  data_memory_ctrl_if #(.DATA_W(8), .ADDR_W(6)) if3 ();

  assign if0.req = t_req[0]; assign if0.we = t_we; assign if0.addr = t_addr[3:0]; assign if0.wdata = t_wdata[3:0];
  assign if1.req = t_req[1]; assign if1.we = t_we; assign if1.addr = t_addr[3:0]; assign if1.wdata = t_wdata[3:0];
  assign if2.req = t_req[2]; assign if2.we = t_we; assign if2.addr = t_addr[3:0]; assign if2.wdata = t_wdata[3:0];
  assign if3.req = t_req[3]; assign if3.we = t_we; assign if3.addr = t_addr;      assign if3.wdata = t_wdata;

  assign m_ready = {if3.ready, if2.ready, if1.ready, if0.ready};
  assign m_ack   = {if3.ack, if2.ack, if1.ack, if0.ack};
  assign m_rdata[0] = {4'h0, if0.rdata};
  assign m_rdata[1] = {4'h0, if1.rdata};
  assign m_rdata[2] = {4'h0, if2.rdata};
  assign m_rdata[3] = if3.rdata;

  data_memory_ctrl #(.DATA_W(4), .ADDR_W(4), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  data_memory_ctrl #(.DATA_W(4), .ADDR_W(4), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  data_memory_ctrl #(.DATA_W(4), .ADDR_W(4), .WAIT_CYCLES(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  data_memory_ctrl #(.DATA_W(8), .ADDR_W(6), .WAIT_CYCLES(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model view of a reset: rdata clears; with the clear sweep every word becomes a known 0.
  task automatic mdl_reset();
    for (int d = 0; d < 4; d++) begin
      mdl_rd[d] = 8'h00;
`ifdef DMEM_CLEAR_EN
      for (int a = 0; a < 64; a++) begin
        mdl_mem[d][a] = 8'h00;
        mdl_vld[d][a] = 1'b1;
      end
`endif
    end
  endtask

  // One access on instance d, entered and left on a falling edge.
  // lat = number of the cycle after the accepting edge in which ack was seen (-1 if never).
  task automatic access(input int d, input bit we, input logic [5:0] a, input logic [7:0] wd,
                        input bit hold, output int lat, output logic [7:0] rd);
    int w;
    lat = -1;
    rd  = 8'h00;
    t_we = we; t_addr = a; t_wdata = wd; t_req[d] = 1'b1;
    w = 0;
    while (!m_ready[d] && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!m_ready[d]) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout dut%0d: ready stayed 0 for %0d cycles, required 1", d, w);
      t_req[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      // Scramble the bus after acceptance; the latched copy must be used.
      t_req[d] = 1'b0;
      t_we     = 1'($urandom);
      t_addr   = 6'($urandom);
      t_wdata  = 8'($urandom);
    end
    for (int n = 1; n <= 20; n++) begin
      if (m_ack[d]) begin
        lat = n;
        rd  = m_rdata[d];
        break;
      end
      @(negedge clk);
    end
    t_req[d] = 1'b0;
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout dut%0d: no ack within 20 cycles, required one", d);
    end
  endtask

  // Model-checked access: latency from the instance's wait setting, data from the model.
  task automatic op(input int d, input bit we, input logic [5:0] a_in, input logic [7:0] wd_in,
                    input string nm);
    int         lat;
    logic [7:0] rd;
    logic [5:0] a;
    logic [7:0] wd;
    logic [7:0] exp;
    a  = a_in  & 6'(AMASK[d]);
    wd = wd_in & 8'(DMASK[d]);
    access(d, we, a, wd, 1'b0, lat, rd);
    chk({nm, "_lat"}, 32'(lat), 32'(WAITV[d] + 1));
    if (we) begin
      exp = mdl_rd[d];
      mdl_mem[d][a] = wd;
      mdl_vld[d][a] = 1'b1;
    end else begin
      exp = mdl_mem[d][a];
    end
    chk({nm, "_rdata"}, 32'(rd), 32'(exp));
    mdl_rd[d] = exp;
  endtask

  typedef struct {
    int         dut;
    bit         we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t       tbl [6];
  int         lat;
  int         cnt;
  logic [7:0] rd;
  longint     t_prev;

  initial begin
    tbl[0] = '{0, 1'b1, 6'd3,  8'h0A, 8'h00, 2};  // write 0xA @3, rdata keeps reset 0
    tbl[1] = '{0, 1'b0, 6'd3,  8'h00, 8'h0A, 2};  // read back 0xA
    tbl[2] = '{3, 1'b1, 6'd63, 8'hA5, 8'h00, 2};  // wide config, top address
    tbl[3] = '{3, 1'b0, 6'd63, 8'h00, 8'hA5, 2};
    tbl[4] = '{3, 1'b1, 6'd10, 8'h3C, 8'hA5, 2};  // write ack leaves last read value
    tbl[5] = '{2, 1'b1, 6'd7,  8'h09, 8'h00, 4};  // three wait states

    for (int d = 0; d < 4; d++)
      for (int a = 0; a < 64; a++) begin
        mdl_mem[d][a] = 8'h00;
        mdl_vld[d][a] = 1'b0;
      end

    rst_n = 1'b1; t_req = 4'h0; t_we = 1'b0; t_addr = 6'h0; t_wdata = 8'h0;
    #2 rst_n = 1'b0;
    mdl_reset();
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
`ifdef DMEM_CLEAR_EN
      chk($sformatf("reset_ready%0d", d), 32'(m_ready[d]), 32'd0);
`else
      chk($sformatf("reset_ready%0d", d), 32'(m_ready[d]), 32'd1);
`endif
      chk($sformatf("reset_ack%0d", d), 32'(m_ack[d]), 32'd0);
      chk($sformatf("reset_rdata%0d", d), 32'(m_rdata[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      access(tbl[i].dut, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, lat, rd);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      if (tbl[i].we) begin
        mdl_mem[tbl[i].dut][tbl[i].addr] = tbl[i].wdata;
        mdl_vld[tbl[i].dut][tbl[i].addr] = 1'b1;
      end
      mdl_rd[tbl[i].dut] = tbl[i].exp_rd;
    end

    // Zero wait states: fill 0..15 with i, then back-to-back reads, one ack per 2 cycles
    for (int i = 0; i < 16; i++) op(1, 1'b1, 6'(i), 8'(i), $sformatf("fill%0d", i));
    t_prev = 0;
    for (int i = 0; i < 16; i++) begin
      access(1, 1'b0, 6'(i), 8'h00, 1'b0, lat, rd);
      chk($sformatf("b2b%0d_lat", i), 32'(lat), 32'd1);
      chk($sformatf("b2b%0d_rdata", i), 32'(rd), 32'(i));
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), 32'($time - t_prev), 32'(2 * PERIOD));
      t_prev = $time;
    end
    mdl_rd[1] = 8'h0F;

    // req held through the wait states: exactly one accept and one ack at E0+4
    access(2, 1'b0, 6'd7, 8'h00, 1'b1, lat, rd);
    chk("hold_lat", 32'(lat), 32'd4);
    chk("hold_rdata", 32'(rd), 32'(mdl_mem[2][7]));
    mdl_rd[2] = mdl_mem[2][7];
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (m_ack[2]) cnt++;
    end
    chk("hold_extra_acks", 32'(cnt), 32'd0);

    // Reset while a read waits: access dropped, no ack, rdata cleared, earlier write kept
    t_we = 1'b0; t_addr = 6'd7; t_req[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_req[2] = 1'b0;
    rst_n = 1'b0;
    mdl_reset();
    #1;
`ifndef DMEM_CLEAR_EN
    chk("midrst_ready", 32'(m_ready[2]), 32'd1);
`endif
    chk("midrst_ack", 32'(m_ack[2]), 32'd0);
    chk("midrst_rdata", 32'(m_rdata[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (m_ack[2]) cnt++;
    end
    chk("midrst_no_ack", 32'(cnt), 32'd0);
    chk("midrst_rdata_after", 32'(m_rdata[2]), 32'd0);
    op(2, 1'b0, 6'd7, 8'h00, "midrst_retained");

`ifdef DMEM_CLEAR_EN
    // Clear sweep: preload, reset, ready low for 16 cycles, word reads back as 0
    op(0, 1'b1, 6'd5, 8'h0F, "clr_preload");
    @(negedge clk);
    rst_n = 1'b0;
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (!m_ready[0] && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("clr_busy_cycles", 32'(cnt), 32'(DEPTHV[0]));
    op(0, 1'b0, 6'd5, 8'h00, "clr_readback");
`endif

    // Randomized traffic against the model; reads only target words with known content
    for (int k = 0; k < 150; k++) begin
      int         d;
      logic [5:0] a;
      bit         we;
      d  = $urandom_range(0, 3);
      a  = 6'($urandom) & 6'(AMASK[d]);
      we = 1'($urandom) || !mdl_vld[d][a];
      op(d, we, a, 8'($urandom), $sformatf("rnd%0d_dut%0d", k, d));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
